mash_sample_sequencer: RTL and testbench
========================================

Name: mash_sample_sequencer

Overview:
- Front-end controller for the MASH sigma-delta DAC.
- Accepts PCM samples over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Generates the modulator tick strobe (mod_en) from a programmable clock divider and presents one sample per oversampling period (OSR ticks).
- Sequences clear, soft-start ramp, run and stop, so the truncator/accumulator error registers start from a known state and the output never steps abruptly.

Parameters:
- DW, 16, sample width (signed, two's complement)
- CNT_W, 8, width of the clk_div and osr configuration inputs and their counters
- RAMP_SHIFT, 3, number of ramp steps; ramp output = sample >>> (RAMP_SHIFT-k), k=0..RAMP_SHIFT-1

Ports:
- clck  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- clk_div  in  CNT_W  mod_en period minus 1; static while state!=IDLE
- osr  in  CNT_W  ticks per sample minus 1; static while state!=IDLE
- in_valid  in  1  sample valid
- in_data  in  DW  signed sample
- in_ready  out  1  FIFO not full
- mod_en  out  1  one-clck modulator tick strobe
- mod_x  out  DW  signed sample to modulator, held between sample boundaries
- mod_clr  out  1  one-clck clear pulse to modulator error registers
- busy  out  1  state!=IDLE
- underrun  out  1  sticky: sample boundary reached with FIFO empty in RUN

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, all counters 0, mod_x=0, mod_en=0, mod_clr=0, underrun=0.
- in_ready=0 during reset.
- in_ready = !full, registered-free.
- A push occurs when in_valid&&in_ready, including in IDLE (prefill).
- Push and pop in the same cycle are legal when not full.
- FIFO pointers wrap modulo 2.
- Tick divider runs only when state is not IDLE.
  - tick_cnt counts 0..clk_div; mod_en=1 in the cycle tick_cnt==clk_div, then tick_cnt wraps to 0.
  - clk_div=0 gives mod_en every cycle.
- Sample counter samp_cnt advances on mod_en, 0..osr.
  - A sample boundary is mod_en && samp_cnt==osr.
  - mod_x updates in the cycle after the boundary, so it is stable for exactly osr+1 ticks.
- FSM states IDLE, CLEAR, RAMP, RUN, STOP:
  - IDLE: enable=1 -> CLEAR. Counters held at 0.
  - CLEAR: mod_clr=1 for one cycle; underrun cleared; counters reset; k=0. Next state RAMP.
  - RAMP: at each boundary, pop if non-empty and set mod_x = sample >>> (RAMP_SHIFT-k), then k++. When k==RAMP_SHIFT-1 at the boundary, go to RUN. An empty FIFO at the boundary repeats the previous value without advancing k.
  - RUN: at each boundary, pop and set mod_x = sample. If the FIFO is empty: hold mod_x and set underrun=1.
  - enable=0 in RAMP or RUN: no effect until the next boundary, which then enters STOP (mod_x=0, no pop).
  - STOP: after one full sample period, go to IDLE, flush the FIFO and set mod_x=0.
  - enable=1 during STOP is ignored until IDLE is reached.
  - enable toggling inside CLEAR is ignored.
- The arithmetic right shift preserves sign; no rounding.

Optional Feature:
- MASH_SEQ_UNDERRUN_CNT_EN: adds output underrun_cnt [CNT_W-1:0].
  - Increments at every underrun boundary and saturates at all-ones.
  - Cleared in CLEAR and on reset.
- Without the macro: sticky underrun flag only; port absent.

Decomposition:
- Shared package mash_pkg holds:
  - state enum (IDLE, CLEAR, RAMP, RUN, STOP)
  - DW/CNT_W defaults
  - RAMP_SHIFT default
- One sub-module: mash_tick_gen (tick_cnt + samp_cnt, outputs mod_en and boundary).
- The FIFO stays inline.

Test Plan:
- Reset mid-RUN (clk_div=1, osr=3, streaming): drop rst -> mod_x, mod_en, busy, underrun all 0 immediately; in_ready=1 after release.
- clk_div=2, osr=3, prefill 0x4000, 0x4000, then stream 0x4000:
  - mod_clr pulses once, 1 cycle after enable.
  - mod_en every 3rd cycle.
  - mod_x sequence 0x0800, 0x1000, 0x2000, then 0x4000; each value held 12 clck.
- Negative ramp: samples -0x4000 -> mod_x 0xF800, 0xF000, 0xE000, then 0xC000 (sign kept).
- Underrun: in RUN stop in_valid after the FIFO empties -> mod_x holds the last value, underrun=1 and stays 1. With macro: underrun_cnt counts 1, 2, 3 per boundary.
- Full FIFO: in_valid held in IDLE -> in_ready=0 after 2 pushes; third sample not accepted until the first pop.
- enable=0 mid-sample in RUN -> mod_x changes only at the boundary, to 0 for one sample period; then busy=0 and FIFO empty (in_ready=1).

Source files
------------

// File: rtl/mash_pkg.sv
// Shared definitions for the MASH DAC front-end sample sequencer:
// sequencer state encoding and default widths.
package mash_pkg;

  localparam int DW_DEF         = 16;
  localparam int CNT_W_DEF      = 8;
  localparam int RAMP_SHIFT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    STOP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mash_tick_gen.sv
// Modulator tick divider and per-sample tick counter.
// mod_en strobes once every clk_div+1 cycles while run is high; boundary
// marks the last tick of each sample period (osr+1 ticks per sample).
module mash_tick_gen
  import mash_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] clk_div,
  input  logic [CNT_W-1:0] osr,
  output logic             mod_en,
  output logic             boundary
);

  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] samp_cnt;

  assign mod_en   = run && (tick_cnt == clk_div);
  assign boundary = mod_en && (samp_cnt == osr);

  // Both counters hold at zero whenever the divider is not running.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (!run) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else begin
      tick_cnt <= mod_en ? '0 : tick_cnt + CNT_W'(1);
      if (mod_en) begin
        samp_cnt <= boundary ? '0 : samp_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mash_sample_sequencer.sv
// Front-end controller for the MASH sigma-delta DAC.
// Buffers PCM samples in a 2-entry FIFO, generates the modulator tick and
// sequences clear / soft-start ramp / run / stop so the modulator never sees
// an abrupt step. Optional build macro MASH_SEQ_UNDERRUN_CNT_EN adds a
// saturating underrun_cnt output next to the sticky underrun flag.
module mash_sample_sequencer
  import mash_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RAMP_SHIFT = RAMP_SHIFT_DEF
) (
  input  logic                 clck,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     clk_div,
  input  logic [CNT_W-1:0]     osr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 mod_en,
  output logic signed [DW-1:0] mod_x,
  output logic                 mod_clr,
  output logic                 busy,
  output logic                 underrun
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
  ,
  output logic [CNT_W-1:0]     underrun_cnt
`endif
);

  localparam int K_W = $clog2(RAMP_SHIFT + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(RAMP_SHIFT - 1);

  seq_state_t         state;
  logic [K_W-1:0]     k;
  logic               boundary;
  logic               run;

  logic signed [DW-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic signed [DW-1:0] head;

  // Soft-start scaling: arithmetic shift keeps the sign, truncates toward -inf.
  function automatic logic signed [DW-1:0] ramp_scale(
    input logic signed [DW-1:0] s,
    input logic [K_W-1:0]       step
  );
    return s >>> (RAMP_SHIFT - int'(step));
  endfunction

  assign busy  = (state != IDLE);
  assign run   = (state == RAMP) || (state == RUN) || (state == STOP);

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign in_ready = rst && !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign pop      = boundary && enable && !empty &&
                    ((state == RAMP) || (state == RUN));
  assign flush    = boundary && (state == STOP);

  mash_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clck    (clck),
    .rst     (rst),
    .run     (run),
    .clk_div (clk_div),
    .osr     (osr),
    .mod_en  (mod_en),
    .boundary(boundary)
  );

  // FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clck) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; leaving STOP discards anything left over.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM; mod_x only ever changes on the edge after a boundary.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      mod_x    <= '0;
      mod_clr  <= 1'b0;
      underrun <= 1'b0;
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      mod_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= CLEAR;
            mod_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state    <= RAMP;
          k        <= '0;
          underrun <= 1'b0;
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
          underrun_cnt <= '0;
`endif
        end
        RAMP: begin
          if (boundary) begin
            if (!enable) begin
              state <= STOP;
              mod_x <= '0;
            end else if (!empty) begin
              mod_x <= ramp_scale(head, k);
              if (k == K_LAST) state <= RUN;
              else             k     <= k + K_W'(1);
            end
          end
        end
        RUN: begin
          if (boundary) begin
            if (!enable) begin
              state <= STOP;
              mod_x <= '0;
            end else if (!empty) begin
              mod_x <= head;
            end else begin
              underrun <= 1'b1;
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
              if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
`endif
            end
          end
        end
        STOP: begin
          if (boundary) begin
            state <= IDLE;
            mod_x <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mash_sample_sequencer.sv
// Self-checking bench for mash_sample_sequencer.
module tb_mash_sample_sequencer;

  logic        clck = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  clk_div = '0;
  logic [7:0]  osr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mod_en;
  logic [15:0] mod_x;
  logic        mod_clr;
  logic        busy;
  logic        underrun;
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int clr_pulses = 0;

  logic [15:0] exp_q[$];
  int          en_cnt = 0;
  bit          pending = 1'b0;
  logic [15:0] last_x = '0;

  typedef struct {
    logic [15:0] smp;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
  } vec_t;

  vec_t vecs[6];

  mash_sample_sequencer dut (
    .clck    (clck),
    .rst     (rst),
    .enable  (enable),
    .clk_div (clk_div),
    .osr     (osr),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .mod_en  (mod_en),
    .mod_x   (mod_x),
    .mod_clr (mod_clr),
    .busy    (busy),
    .underrun(underrun)
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial forever #5 clck = ~clck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clck);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    exp_q.delete();
  endtask

  // Scoreboard: one expected mod_x per sample boundary, seen one cycle later;
  // between boundaries mod_x must hold.
  always @(negedge clck) begin
    if (!rst) begin
      en_cnt  = 0;
      pending = 1'b0;
      last_x  = '0;
    end else begin
      if (pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_boundary actual=%h required=none", mod_x);
        end else begin
          check("sb_mod_x", 32'(mod_x), 32'(exp_q.pop_front()));
        end
        pending = 1'b0;
      end else begin
        check("mod_x_hold", 32'(mod_x), 32'(last_x));
      end
      last_x = mod_x;
      if (!busy) en_cnt = 0;
      else if (mod_en) begin
        if (en_cnt == int'(osr)) begin
          pending = 1'b1;
          en_cnt  = 0;
        end else begin
          en_cnt++;
        end
      end
      if (mod_clr) clr_pulses++;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    do_reset();
    clk_div  = 8'd0;
    osr      = 8'd0;
    in_data  = v.smp;
    in_valid = 1'b1;
    step(2);
    check($sformatf("vec%0d_prefill_full", idx), 32'(in_ready), 32'd0);
    exp_q.push_back(v.e0);
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    exp_q.push_back(v.e3);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    enable = 1'b1;
    step(6);
    enable   = 1'b0;
    in_valid = 1'b0;
    step(3);
    check($sformatf("vec%0d_idle", idx), 32'(busy), 32'd0);
    check($sformatf("vec%0d_sb_drained", idx), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h4000, 16'h0800, 16'h1000, 16'h2000, 16'h4000};
    vecs[1] = '{16'hC000, 16'hF800, 16'hF000, 16'hE000, 16'hC000};
    vecs[2] = '{16'h7FFF, 16'h0FFF, 16'h1FFF, 16'h3FFF, 16'h7FFF};
    vecs[3] = '{16'hFFF9, 16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF9};
    vecs[4] = '{16'h0007, 16'h0000, 16'h0001, 16'h0003, 16'h0007};
    vecs[5] = '{16'h8001, 16'hF000, 16'hE000, 16'hC000, 16'h8001};

    // Reset state
    step(1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mod_x", 32'(mod_x), 32'd0);
    check("rst_mod_en", 32'(mod_en), 32'd0);
    check("rst_mod_clr", 32'(mod_clr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b1;
    step(1);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Ramp scaling table
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Main sequence: clk_div=2, osr=3, streaming 0x4000, stop mid-sample
    do_reset();
    clk_div  = 8'd2;
    osr      = 8'd3;
    in_data  = 16'h4000;
    in_valid = 1'b1;
    step(2);
    clr_pulses = 0;
    exp_q.push_back(16'h0800);
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'h2000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    enable = 1'b1;
    step(1);
    check("main_mod_clr_on", 32'(mod_clr), 32'd1);
    check("main_busy", 32'(busy), 32'd1);
    step(1);
    check("main_mod_clr_off", 32'(mod_clr), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("main_mod_en_c%0d", i), 32'(mod_en), 32'((i % 3) == 0));
      step(1);
    end
    step(57);
    enable   = 1'b0;
    in_valid = 1'b0;
    step(19);
    check("main_stop_busy", 32'(busy), 32'd0);
    check("main_stop_in_ready", 32'(in_ready), 32'd1);
    check("main_clr_pulses", 32'(clr_pulses), 32'd1);
    check("main_sb_drained", 32'(exp_q.size()), 32'd0);

    // Restart with no input: a flushed FIFO leaves mod_x at 0
    clk_div = 8'd0;
    osr     = 8'd0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    enable = 1'b1;
    step(3);
    enable = 1'b0;
    step(4);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_sb_drained", 32'(exp_q.size()), 32'd0);

    // Underrun in RUN
    do_reset();
    clk_div  = 8'd0;
    osr      = 8'd1;
    in_data  = 16'h0800;
    in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0200);
    exp_q.push_back(16'h0400);
    repeat (4) exp_q.push_back(16'h0123);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    enable = 1'b1;
    step(4);
    in_data  = 16'h0800;
    in_valid = 1'b1;
    step(1);
    in_data = 16'h0123;
    step(2);
    in_valid = 1'b0;
    step(4);
    check("ur_before", 32'(underrun), 32'd0);
    check("ur_x_before", 32'(mod_x), 32'h0123);
    step(1);
    check("ur_set", 32'(underrun), 32'd1);
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
    check("ur_cnt_1", 32'(underrun_cnt), 32'd1);
`endif
    step(2);
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
    check("ur_cnt_2", 32'(underrun_cnt), 32'd2);
`endif
    step(2);
`ifdef MASH_SEQ_UNDERRUN_CNT_EN
    check("ur_cnt_3", 32'(underrun_cnt), 32'd3);
`endif
    check("ur_x_hold", 32'(mod_x), 32'h0123);
    enable = 1'b0;
    step(5);
    check("ur_sticky", 32'(underrun), 32'd1);
    check("ur_idle", 32'(busy), 32'd0);
    check("ur_sb_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    #1;
    check("ur_rst_clears", 32'(underrun), 32'd0);

    // Full FIFO in IDLE; third sample waits for the first pop
    do_reset();
    clk_div  = 8'd0;
    osr      = 8'd0;
    in_data  = 16'h0111;
    in_valid = 1'b1;
    check("full_empty_ready", 32'(in_ready), 32'd1);
    step(1);
    check("full_one_ready", 32'(in_ready), 32'd1);
    in_data = 16'h0222;
    step(1);
    check("full_two_ready", 32'(in_ready), 32'd0);
    in_data = 16'h0333;
    step(3);
    check("full_held_ready", 32'(in_ready), 32'd0);
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0088);
    exp_q.push_back(16'h0199);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    enable = 1'b1;
    step(2);
    check("full_before_pop", 32'(in_ready), 32'd0);
    step(1);
    check("full_after_pop", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
    step(1);
    enable = 1'b0;
    step(3);
    check("full_idle", 32'(busy), 32'd0);
    check("full_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-RUN: clk_div=1, osr=3, streaming
    do_reset();
    clk_div  = 8'd1;
    osr      = 8'd3;
    in_data  = 16'h2000;
    in_valid = 1'b1;
    step(2);
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0800);
    exp_q.push_back(16'h1000);
    exp_q.push_back(16'h2000);
    enable = 1'b1;
    step(36);
    check("mid_sb_drained", 32'(exp_q.size()), 32'd0);
    check("mid_x_running", 32'(mod_x), 32'h2000);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    enable   = 1'b0;
    #1;
    check("mid_rst_mod_x", 32'(mod_x), 32'd0);
    check("mid_rst_mod_en", 32'(mod_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step(1);
    rst = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
